// File: rtl/riscv_sram_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports of a minimal RISC-V
// core. Halfword-aligned fetches are served as two word reads merged into one 32-bit result.
module riscv_sram_arbiter #(
  parameter int unsigned addr_bits = 14
) (
  input  logic                 clk,
  input  logic                 clk__enable,
  input  logic                 reset,

  input  logic [31:0]          imem_access_req__address,
  input  logic                 imem_access_req__read_enable,
  output logic                 imem_access_resp__wait,
  output logic [31:0]          imem_access_resp__read_data,

  input  logic [31:0]          dmem_access_req__address,
  input  logic [3:0]           dmem_access_req__byte_enable,
  input  logic                 dmem_access_req__read_enable,
  input  logic                 dmem_access_req__write_enable,
  input  logic [31:0]          dmem_access_req__write_data,
  output logic                 dmem_access_resp__wait,
  output logic [31:0]          dmem_access_resp__read_data,

  output logic                 sram_select,
  output logic                 sram_read_not_write,
  output logic [addr_bits-1:0] sram_address,
  output logic [3:0]           sram_write_enable,
  output logic [31:0]          sram_write_data,
  input  logic [31:0]          sram_read_data
);

  typedef enum logic [2:0] {
    StIdle,
    StIData,
    StILo,
    StIHi,
    StDData
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          hold_q, hold_d;
  logic                 last_dmem_q, last_dmem_d;

  logic                 imem_req;
  logic                 dmem_req;
  logic                 dmem_wr;
  logic                 grant_dmem;
  logic [addr_bits-1:0] imem_word;
  logic [addr_bits-1:0] imem_word_next;
  logic [addr_bits-1:0] dmem_word;
  logic                 unused_addr;

  assign imem_req       = imem_access_req__read_enable;
  assign dmem_wr        = dmem_access_req__write_enable;
  assign dmem_req       = dmem_access_req__read_enable | dmem_access_req__write_enable;
  assign imem_word      = imem_access_req__address[addr_bits+1:2];
  assign imem_word_next = imem_word + addr_bits'(1);
  assign dmem_word      = dmem_access_req__address[addr_bits+1:2];
  // dmem wins unless imem also requests and dmem held the previous grant.
  assign grant_dmem     = dmem_req & (~imem_req | ~last_dmem_q);

  assign unused_addr = ^{imem_access_req__address[31:addr_bits+2], imem_access_req__address[0],
                         dmem_access_req__address[31:addr_bits+2], dmem_access_req__address[1:0]};

  always_comb begin
    state_d                     = state_q;
    hold_d                      = hold_q;
    last_dmem_d                 = last_dmem_q;
    sram_select                 = 1'b0;
    sram_read_not_write         = 1'b1;
    sram_address                = '0;
    sram_write_enable           = 4'b0000;
    sram_write_data             = 32'h0;
    imem_access_resp__wait      = imem_req;
    dmem_access_resp__wait      = dmem_req;
    imem_access_resp__read_data = sram_read_data;
    dmem_access_resp__read_data = sram_read_data;

    unique case (state_q)
      StIdle: begin
        if (grant_dmem) begin
          last_dmem_d  = 1'b1;
          sram_select  = 1'b1;
          sram_address = dmem_word;
          if (dmem_wr) begin
            sram_read_not_write    = 1'b0;
            sram_write_enable      = dmem_access_req__byte_enable;
            sram_write_data        = dmem_access_req__write_data;
            dmem_access_resp__wait = 1'b0;
          end else begin
            state_d = StDData;
          end
        end else if (imem_req) begin
          last_dmem_d  = 1'b0;
          sram_select  = 1'b1;
          sram_address = imem_word;
          state_d      = imem_access_req__address[1] ? StILo : StIData;
        end
      end
      StDData: begin
        dmem_access_resp__wait = 1'b0;
        state_d                = StIdle;
      end
      StIData: begin
        imem_access_resp__wait = 1'b0;
        state_d                = StIdle;
      end
      StILo: begin
        // An abandoned split fetch skips the second read entirely.
        if (imem_req) begin
          hold_d       = sram_read_data[31:16];
          sram_select  = 1'b1;
          sram_address = imem_word_next;
          state_d      = StIHi;
        end else begin
          state_d = StIdle;
        end
      end
      StIHi: begin
        imem_access_resp__wait      = 1'b0;
        imem_access_resp__read_data = {sram_read_data[15:0], hold_q};
        state_d                     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      sram_select                 = 1'b0;
      sram_read_not_write         = 1'b0;
      sram_address                = '0;
      sram_write_enable           = 4'b0000;
      sram_write_data             = 32'h0;
      imem_access_resp__wait      = 1'b1;
      dmem_access_resp__wait      = 1'b1;
      imem_access_resp__read_data = 32'h0;
      dmem_access_resp__read_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (clk__enable) begin
      if (reset) begin
        state_q     <= StIdle;
        hold_q      <= 16'h0;
        last_dmem_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        hold_q      <= hold_d;
        last_dmem_q <= last_dmem_d;
      end
    end
  end

endmodule

// File: tb/tb_riscv_sram_arbiter.sv
// Self-checking bench for riscv_sram_arbiter: behavioural SRAM model, a table of data-port
// vectors and hand-written sequences for fetch, contention, abort and reset corner cases.
module tb_riscv_sram_arbiter;
  localparam int unsigned AddrBits = 14;

  logic                clk;
  logic                clk_en;
  logic                reset;
  logic [31:0]         i_addr;
  logic                i_re;
  logic                i_wait;
  logic [31:0]         i_rdata;
  logic [31:0]         d_addr;
  logic [3:0]          d_be;
  logic                d_re;
  logic                d_we;
  logic [31:0]         d_wdata;
  logic                d_wait;
  logic [31:0]         d_rdata;
  logic                sram_select;
  logic                sram_rnw;
  logic [AddrBits-1:0] sram_address;
  logic [3:0]          sram_we;
  logic [31:0]         sram_wdata;
  logic [31:0]         sram_rdata;

  logic [31:0] mem [0:(1<<AddrBits)-1];

  int checks;
  int errors;

  typedef struct {
    logic        wr;
    logic        both;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_word;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] exp_dwait;
  logic [7:0] exp_iwait;

  riscv_sram_arbiter #(.addr_bits(AddrBits)) dut (
    .clk                          (clk),
    .clk__enable                  (clk_en),
    .reset                        (reset),
    .imem_access_req__address     (i_addr),
    .imem_access_req__read_enable (i_re),
    .imem_access_resp__wait       (i_wait),
    .imem_access_resp__read_data  (i_rdata),
    .dmem_access_req__address     (d_addr),
    .dmem_access_req__byte_enable (d_be),
    .dmem_access_req__read_enable (d_re),
    .dmem_access_req__write_enable(d_we),
    .dmem_access_req__write_data  (d_wdata),
    .dmem_access_resp__wait       (d_wait),
    .dmem_access_resp__read_data  (d_rdata),
    .sram_select                  (sram_select),
    .sram_read_not_write          (sram_rnw),
    .sram_address                 (sram_address),
    .sram_write_enable            (sram_we),
    .sram_write_data              (sram_wdata),
    .sram_read_data               (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency SRAM with per-byte write enables.
  always @(posedge clk) begin
    if (clk_en && sram_select) begin
      if (sram_rnw) begin
        sram_rdata <= mem[sram_address];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_address][8*b +: 8] = sram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_re = 1'b0;
    d_re = 1'b0;
    d_we = 1'b0;
    d_be = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AddrBits); i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;
    clk_en  = 1'b1;
    reset   = 1'b1;
    i_addr  = 32'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    idle_inputs();
    mem[32'h10] = 32'h11223344;
    mem[32'h11] = 32'hCAFEF00D;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0080, 4'b0101, 32'hDEADBEEF, 32'h20, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        32'h20, 32'h00AD00EF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 4'b1010, 32'h12345678, 32'h20, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0083, 4'b0000, 32'h0,        32'h20, 32'h12AD56EF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0084, 4'b1111, 32'hA5A5A5A5, 32'h21, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0001_0084, 4'b0000, 32'h0,        32'h21, 32'hA5A5A5A5};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0080, 4'b0000, 32'hFFFFFFFF, 32'h20, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        32'h20, 32'h12AD56EF};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0088, 4'b1111, 32'h0BADF00D, 32'h22, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0088, 4'b0000, 32'h0,        32'h22, 32'h0BADF00D};

    tick();
    tick();

    // Reset held with both ports requesting.
    i_re   = 1'b1;
    i_addr = 32'h40;
    d_re   = 1'b1;
    d_addr = 32'h44;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_select", 32'(sram_select), 32'h0);
      chk("reset_iwait", 32'(i_wait), 32'h1);
      chk("reset_dwait", 32'(d_wait), 32'h1);
      chk("reset_irdata", i_rdata, 32'h0);
      tick();
    end
    reset = 1'b0;

    // Contention: completions alternate dmem, imem, dmem, imem.
    exp_dwait = 8'b1101_1101;
    exp_iwait = 8'b0111_0111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("cont_dwait", 32'(d_wait), 32'(exp_dwait[c]));
      chk("cont_iwait", 32'(i_wait), 32'(exp_iwait[c]));
      if (c % 2 == 0) chk("cont_addr", 32'(sram_address), (c % 4 == 0) ? 32'h11 : 32'h10);
      if (!exp_dwait[c]) chk("cont_drdata", d_rdata, 32'hCAFEF00D);
      if (!exp_iwait[c]) chk("cont_irdata", i_rdata, 32'h11223344);
      tick();
    end
    idle_inputs();

    // Data-port vector table.
    for (int v = 0; v < 10; v++) begin
      d_addr  = vecs[v].addr;
      d_be    = vecs[v].be;
      d_wdata = vecs[v].wdata;
      d_we    = vecs[v].wr;
      d_re    = ~vecs[v].wr | vecs[v].both;
      @(negedge clk);
      chk("vec_select", 32'(sram_select), 32'h1);
      chk("vec_addr", 32'(sram_address), vecs[v].exp_word);
      if (vecs[v].wr) begin
        chk("vec_wr_dwait", 32'(d_wait), 32'h0);
        chk("vec_wr_rnw", 32'(sram_rnw), 32'h0);
        chk("vec_wr_we", 32'(sram_we), 32'(vecs[v].be));
        chk("vec_wr_data", sram_wdata, vecs[v].wdata);
        tick();
      end else begin
        chk("vec_rd_dwait0", 32'(d_wait), 32'h1);
        chk("vec_rd_rnw", 32'(sram_rnw), 32'h1);
        tick();
        @(negedge clk);
        chk("vec_rd_dwait1", 32'(d_wait), 32'h0);
        chk("vec_rd_data", d_rdata, vecs[v].exp_rdata);
        tick();
      end
    end
    idle_inputs();

    // Aligned fetch.
    i_re   = 1'b1;
    i_addr = 32'h40;
    @(negedge clk);
    chk("al_addr", 32'(sram_address), 32'h10);
    chk("al_wait0", 32'(i_wait), 32'h1);
    tick();
    @(negedge clk);
    chk("al_wait1", 32'(i_wait), 32'h0);
    chk("al_data", i_rdata, 32'h11223344);
    tick();

    // Split fetch with a dmem read arriving between the halves.
    mem[32'h10] = 32'hAAAA1111;
    mem[32'h11] = 32'h2222BBBB;
    i_addr = 32'h42;
    @(negedge clk);
    chk("sp_addr0", 32'(sram_address), 32'h10);
    chk("sp_wait0", 32'(i_wait), 32'h1);
    tick();
    d_re   = 1'b1;
    d_addr = 32'h88;
    @(negedge clk);
    chk("sp_select1", 32'(sram_select), 32'h1);
    chk("sp_addr1", 32'(sram_address), 32'h11);
    chk("sp_wait1", 32'(i_wait), 32'h1);
    chk("sp_dwait1", 32'(d_wait), 32'h1);
    tick();
    @(negedge clk);
    chk("sp_wait2", 32'(i_wait), 32'h0);
    chk("sp_data", i_rdata, 32'hBBBBAAAA);
    chk("sp_dwait2", 32'(d_wait), 32'h1);
    chk("sp_select2", 32'(sram_select), 32'h0);
    tick();
    i_re = 1'b0;
    @(negedge clk);
    chk("sp_daddr", 32'(sram_address), 32'h22);
    chk("sp_dwait3", 32'(d_wait), 32'h1);
    tick();
    @(negedge clk);
    chk("sp_dwait4", 32'(d_wait), 32'h0);
    chk("sp_ddata", d_rdata, 32'h0BADF00D);
    tick();
    idle_inputs();

    // Split fetch wrapping from the last word to word 0.
    mem[0]                   = 32'h77778888;
    mem[(1 << AddrBits) - 1] = 32'h12345678;
    i_re   = 1'b1;
    i_addr = 32'h0000_FFFE;
    @(negedge clk);
    chk("wr_addr0", 32'(sram_address), 32'h3FFF);
    tick();
    @(negedge clk);
    chk("wr_select1", 32'(sram_select), 32'h1);
    chk("wr_addr1", 32'(sram_address), 32'h0);
    tick();
    @(negedge clk);
    chk("wr_wait2", 32'(i_wait), 32'h0);
    chk("wr_data", i_rdata, 32'h88881234);
    tick();

    // Abort in the first half of a split fetch.
    i_addr = 32'h42;
    tick();
    i_re = 1'b0;
    @(negedge clk);
    chk("ab_select", 32'(sram_select), 32'h0);
    chk("ab_iwait", 32'(i_wait), 32'h0);
    tick();
    d_we    = 1'b1;
    d_be    = 4'b1111;
    d_addr  = 32'h90;
    d_wdata = 32'h13579BDF;
    @(negedge clk);
    chk("ab_idle_dwait", 32'(d_wait), 32'h0);
    chk("ab_idle_addr", 32'(sram_address), 32'h24);
    chk("ab_idle_rnw", 32'(sram_rnw), 32'h0);
    tick();
    idle_inputs();

    // Reset asserted in the second half of a split fetch.
    i_re   = 1'b1;
    i_addr = 32'h42;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mr_iwait", 32'(i_wait), 32'h1);
    chk("mr_select", 32'(sram_select), 32'h0);
    chk("mr_irdata", i_rdata, 32'h0);
    tick();
    reset   = 1'b0;
    i_re    = 1'b0;
    d_we    = 1'b1;
    d_be    = 4'b1111;
    d_addr  = 32'h94;
    d_wdata = 32'h2468ACE0;
    @(negedge clk);
    chk("mr_hold", 32'(dut.hold_q), 32'h0);
    chk("mr_idle_dwait", 32'(d_wait), 32'h0);
    chk("mr_idle_select", 32'(sram_select), 32'h1);
    chk("mr_idle_addr", 32'(sram_address), 32'h25);
    tick();
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
